// File: rtl/fetch_pc_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl_if
// Bundles the branch predictor <-> fetch PC controller signals.
//   Predictor -> fetch : if_prediction, if_PBT, id_jump_in_bht,
//                        exe_correction, exe_PBT, exe_CNI
//   Fetch -> predictor : if_PC (tag lookup), ISR_running (tag match qualifier)
// Modports:
//   master : predictor side
//   slave  : fetch PC controller side
// -----------------------------------------------------------------------------
interface fetch_pc_ctrl_if;
  logic        if_prediction;
  logic [10:0] if_PBT;
  logic        id_jump_in_bht;
  logic [1:0]  exe_correction;
  logic [10:0] exe_PBT;
  logic [10:0] exe_CNI;
  logic [10:0] if_PC;
  logic        ISR_running;

  modport master (
    output if_prediction, if_PBT, id_jump_in_bht, exe_correction, exe_PBT, exe_CNI,
    input  if_PC, ISR_running
  );

  modport slave (
    input  if_prediction, if_PBT, id_jump_in_bht, exe_correction, exe_PBT, exe_CNI,
    output if_PC, ISR_running
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl
// Owns the 11-bit (halfword) fetch PC. Each unstalled cycle it selects the next
// PC, in priority order, from: EXE misprediction correction (live or pending),
// interrupt return, interrupt entry, un-predicted ID jump, IF prediction, and
// the sequential increment. Generates the pipeline squash strobes and the
// ISR_running flag.
//
// Ports:
//   CLK, nrst         clock, asynchronous active-low reset
//   en                global enable, 0 freezes all state
//   stall             pipeline stall, holds PC/FSM, latches EXE corrections
//   if_is_compressed  instruction at if_PC is 16-bit (advance by 1 halfword)
//   id_is_jump, id_branchtarget  jump decoded in ID and its target
//   isr_req, isr_ret  interrupt request (level) / return decoded in ID
//   bp (slave)        predictor interface, also carries if_PC and ISR_running
//   squash_if/_id     kill the instruction in IF/ID resp. ID/EXE (this cycle)
//   redirect_src      source selected this cycle (0 seq, 1 corr, 2 ret,
//                     3 isr entry, 4 ID jump, 5 prediction)
// Optional (macro FETCH_PC_PERF_EN): mispredict_cnt, redirect_cnt saturating
// 16-bit counters of applied corrections and of applied other redirects.
// -----------------------------------------------------------------------------
module fetch_pc_ctrl #(
  parameter logic [10:0] RESET_PC   = 11'h000,
  parameter logic [10:0] ISR_VECTOR = 11'h100
) (
  input  logic                 CLK,
  input  logic                 nrst,
  input  logic                 en,
  input  logic                 stall,
  input  logic                 if_is_compressed,
  input  logic                 id_is_jump,
  input  logic [10:0]          id_branchtarget,
  input  logic                 isr_req,
  input  logic                 isr_ret,
  fetch_pc_ctrl_if.slave       bp,
  output logic                 squash_if,
  output logic                 squash_id,
  output logic [2:0]           redirect_src
`ifdef FETCH_PC_PERF_EN
  ,
  output logic [15:0]          mispredict_cnt,
  output logic [15:0]          redirect_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_FLUSH2 = 1'b1
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [10:0] if_pc_r, if_pc_nxt_s;
  logic        isr_running_r, isr_running_nxt_s;
  logic [10:0] saved_pc_r, saved_pc_nxt_s;
  logic        pend_v_r, pend_v_nxt_s;
  logic [10:0] pend_pc_r, pend_pc_nxt_s;
  logic [10:0] seq_pc_s;
  logic [10:0] corr_pc_s;
  logic        squash_if_s, squash_id_s;
  logic [2:0]  src_s;
  logic        p1_apply_s;
  logic        other_apply_s;

  // Next-PC selection, FSM next state and squash/debug outputs
  always_comb begin
    state_nxt_s       = state_r;
    if_pc_nxt_s       = if_pc_r;
    isr_running_nxt_s = isr_running_r;
    saved_pc_nxt_s    = saved_pc_r;
    pend_v_nxt_s      = pend_v_r;
    pend_pc_nxt_s     = pend_pc_r;
    squash_if_s       = 1'b0;
    squash_id_s       = 1'b0;
    src_s             = 3'd0;
    p1_apply_s        = 1'b0;
    other_apply_s     = 1'b0;
    // 11-bit add wraps 7FF+1 to 000 naturally
    seq_pc_s          = if_pc_r + (if_is_compressed ? 11'd1 : 11'd2);
    corr_pc_s         = bp.exe_correction[0] ? bp.exe_PBT : bp.exe_CNI;

    if (!en) begin
      // everything holds
      state_nxt_s = state_r;
    end else if (stall) begin
      // a correction seen while stalled is remembered; newest one wins
      if (bp.exe_correction[1]) begin
        pend_v_nxt_s  = 1'b1;
        pend_pc_nxt_s = corr_pc_s;
      end else begin
        pend_v_nxt_s  = pend_v_r;
      end
    end else if (bp.exe_correction[1] || pend_v_r) begin
      // a live correction is newer than a pending one, so it takes precedence
      if_pc_nxt_s  = bp.exe_correction[1] ? corr_pc_s : pend_pc_r;
      pend_v_nxt_s = 1'b0;
      squash_if_s  = 1'b1;
      squash_id_s  = 1'b1;
      src_s        = 3'd1;
      p1_apply_s   = 1'b1;
      state_nxt_s  = ST_FLUSH2;
    end else if (state_r == ST_FLUSH2) begin
      // second flush cycle: only a correction may redirect, all else deferred
      if_pc_nxt_s = seq_pc_s;
      squash_if_s = 1'b1;
      squash_id_s = 1'b1;
      state_nxt_s = ST_RUN;
    end else if (isr_ret && isr_running_r) begin
      if_pc_nxt_s       = saved_pc_r;
      isr_running_nxt_s = 1'b0;
      squash_if_s       = 1'b1;
      src_s             = 3'd2;
      other_apply_s     = 1'b1;
    end else if (isr_req && !isr_running_r) begin
      if_pc_nxt_s       = ISR_VECTOR;
      saved_pc_nxt_s    = if_pc_r;
      isr_running_nxt_s = 1'b1;
      squash_if_s       = 1'b1;
      src_s             = 3'd3;
      other_apply_s     = 1'b1;
    end else if (id_is_jump && !bp.id_jump_in_bht) begin
      if_pc_nxt_s   = id_branchtarget;
      squash_if_s   = 1'b1;
      src_s         = 3'd4;
      other_apply_s = 1'b1;
    end else if (bp.if_prediction) begin
      if_pc_nxt_s   = bp.if_PBT;
      src_s         = 3'd5;
      other_apply_s = 1'b1;
    end else begin
      if_pc_nxt_s = seq_pc_s;
    end
  end

  // State registers: PC, FSM, ISR context and pending correction
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state_r       <= ST_RUN;
      if_pc_r       <= RESET_PC;
      isr_running_r <= 1'b0;
      saved_pc_r    <= 11'h000;
      pend_v_r      <= 1'b0;
      pend_pc_r     <= 11'h000;
    end else begin
      state_r       <= state_nxt_s;
      if_pc_r       <= if_pc_nxt_s;
      isr_running_r <= isr_running_nxt_s;
      saved_pc_r    <= saved_pc_nxt_s;
      pend_v_r      <= pend_v_nxt_s;
      pend_pc_r     <= pend_pc_nxt_s;
    end
  end

  assign bp.if_PC       = if_pc_r;
  assign bp.ISR_running = isr_running_r;
  assign squash_if      = squash_if_s;
  assign squash_id      = squash_id_s;
  assign redirect_src   = src_s;

`ifdef FETCH_PC_PERF_EN
  logic [15:0] mis_cnt_r;
  logic [15:0] red_cnt_r;

  // Saturating performance counters; apply strobes are already gated by en/stall
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      mis_cnt_r <= 16'h0000;
      red_cnt_r <= 16'h0000;
    end else begin
      if (p1_apply_s && (mis_cnt_r != 16'hFFFF)) begin
        mis_cnt_r <= mis_cnt_r + 16'd1;
      end else begin
        mis_cnt_r <= mis_cnt_r;
      end
      if (other_apply_s && (red_cnt_r != 16'hFFFF)) begin
        red_cnt_r <= red_cnt_r + 16'd1;
      end else begin
        red_cnt_r <= red_cnt_r;
      end
    end
  end

  assign mispredict_cnt = mis_cnt_r;
  assign redirect_cnt   = red_cnt_r;
`else
  logic unused_apply_s;
  assign unused_apply_s = p1_apply_s ^ other_apply_s;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_ctrl
// Driver applies one stimulus per cycle at the falling edge and pushes the
// expected outputs for that cycle (from a reference model of the PC rules)
// into a queue; an independent monitor samples just before the rising edge
// and pops/compares.
// -----------------------------------------------------------------------------
module tb_fetch_pc_ctrl;

  localparam int RST_PC = 'h000;
  localparam int VEC_PC = 'h100;

  logic        CLK;
  logic        nrst;
  logic        en;
  logic        stall;
  logic        if_is_compressed;
  logic        id_is_jump;
  logic [10:0] id_branchtarget;
  logic        isr_req;
  logic        isr_ret;
  logic        squash_if;
  logic        squash_id;
  logic [2:0]  redirect_src;
`ifdef FETCH_PC_PERF_EN
  logic [15:0] mispredict_cnt;
  logic [15:0] redirect_cnt;
`endif

  fetch_pc_ctrl_if bp ();

  fetch_pc_ctrl dut (
    .CLK              (CLK),
    .nrst             (nrst),
    .en               (en),
    .stall            (stall),
    .if_is_compressed (if_is_compressed),
    .id_is_jump       (id_is_jump),
    .id_branchtarget  (id_branchtarget),
    .isr_req          (isr_req),
    .isr_ret          (isr_ret),
    .bp               (bp.slave),
    .squash_if        (squash_if),
    .squash_id        (squash_id),
    .redirect_src     (redirect_src)
`ifdef FETCH_PC_PERF_EN
    ,
    .mispredict_cnt   (mispredict_cnt),
    .redirect_cnt     (redirect_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit       rst;
    bit       en;
    bit       stall;
    bit       comp;
    bit       pred;
    int       pbt;
    bit       jmp;
    bit       inbht;
    int       jt;
    int       corr;
    int       epbt;
    int       ecni;
    bit       ireq;
    bit       iret;
  } stim_t;

  typedef struct {
    int pc;
    int isr;
    int sqi;
    int sqd;
    int src;
    int mis;
    int red;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  int m_pc;
  int m_isr;
  int m_saved;
  int m_flush_left;   // extra squash cycles still owed after a correction
  int m_pend[$];      // correction remembered during stall (at most one)
  int m_mis;
  int m_red;

  function automatic void model_reset();
    m_pc = RST_PC; m_isr = 0; m_saved = 0; m_flush_left = 0;
    m_pend.delete(); m_mis = 0; m_red = 0;
  endfunction

  function automatic int sat_inc(int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Expected outputs for this cycle, then advance the model across the edge
  function automatic exp_t model_step(stim_t s);
    exp_t e;
    int   tgt;
    e.pc = m_pc; e.isr = m_isr; e.sqi = 0; e.sqd = 0; e.src = 0;
    e.mis = m_mis; e.red = m_red;
    if (s.rst) begin
      model_reset();
      e.pc = RST_PC; e.isr = 0; e.mis = 0; e.red = 0;
      return e;
    end
    if (!s.en) return e;
    if (s.stall) begin
      if (s.corr >= 2) begin
        m_pend.delete();
        m_pend.push_back((s.corr == 3) ? s.epbt : s.ecni);
      end
      return e;
    end
    if (s.corr >= 2 || m_pend.size() > 0) begin
      tgt = (s.corr >= 2) ? ((s.corr == 3) ? s.epbt : s.ecni) : m_pend[0];
      m_pend.delete();
      m_pc = tgt; m_flush_left = 1;
      e.sqi = 1; e.sqd = 1; e.src = 1; m_mis = sat_inc(m_mis);
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      e.sqi = 1; e.sqd = 1;
      m_pc = (m_pc + (s.comp ? 1 : 2)) % 2048;
    end else if (s.iret && m_isr == 1) begin
      m_pc = m_saved; m_isr = 0; e.sqi = 1; e.src = 2; m_red = sat_inc(m_red);
    end else if (s.ireq && m_isr == 0) begin
      m_saved = m_pc; m_pc = VEC_PC; m_isr = 1; e.sqi = 1; e.src = 3;
      m_red = sat_inc(m_red);
    end else if (s.jmp && !s.inbht) begin
      m_pc = s.jt; e.sqi = 1; e.src = 4; m_red = sat_inc(m_red);
    end else if (s.pred) begin
      m_pc = s.pbt; e.src = 5; m_red = sat_inc(m_red);
    end else begin
      m_pc = (m_pc + (s.comp ? 1 : 2)) % 2048;
    end
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.en = 1; s.stall = 0; s.comp = 0; s.pred = 0; s.pbt = 0;
    s.jmp = 0; s.inbht = 0; s.jt = 0; s.corr = 0; s.epbt = 0; s.ecni = 0;
    s.ireq = 0; s.iret = 0;
    return s;
  endfunction

  task automatic step(input stim_t s_in);
    stim_t s;
    s = s_in;
    @(negedge CLK);
    if (s.rst) begin
      s = idle();
      s.rst = 1; s.en = 0;
    end
    nrst                    = s.rst ? 1'b0 : 1'b1;
    en                      = s.en;
    stall                   = s.stall;
    if_is_compressed        = s.comp;
    bp.if_prediction        = s.pred;
    bp.if_PBT               = 11'(s.pbt);
    id_is_jump              = s.jmp;
    bp.id_jump_in_bht       = s.inbht;
    id_branchtarget         = 11'(s.jt);
    bp.exe_correction       = 2'(s.corr);
    bp.exe_PBT              = 11'(s.epbt);
    bp.exe_CNI              = 11'(s.ecni);
    isr_req                 = s.ireq;
    isr_ret                 = s.iret;
    exp_q.push_back(model_step(s));
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: sample just before the rising edge and check against the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("if_PC",        int'(bp.if_PC),       e.pc);
        chk("ISR_running",  int'(bp.ISR_running), e.isr);
        chk("squash_if",    int'(squash_if),      e.sqi);
        chk("squash_id",    int'(squash_id),      e.sqd);
        chk("redirect_src", int'(redirect_src),   e.src);
`ifdef FETCH_PC_PERF_EN
        chk("mispredict_cnt", int'(mispredict_cnt), e.mis);
        chk("redirect_cnt",   int'(redirect_cnt),   e.red);
`endif
      end
    end
  end

  initial begin
    stim_t s;
    nrst = 1'b0; en = 1'b0; stall = 1'b0; if_is_compressed = 1'b0;
    id_is_jump = 1'b0; id_branchtarget = 11'h000; isr_req = 1'b0; isr_ret = 1'b0;
    bp.if_prediction = 1'b0; bp.if_PBT = 11'h000; bp.id_jump_in_bht = 1'b0;
    bp.exe_correction = 2'b00; bp.exe_PBT = 11'h000; bp.exe_CNI = 11'h000;
    model_reset();

    // reset, then sequential fetch 000,002,004,005,007
    s = idle(); s.rst = 1; step(s);
    s = idle(); step(s);
    s = idle(); step(s);
    s = idle(); s.comp = 1; step(s);
    s = idle(); step(s);
    s = idle(); step(s);

    // prediction: reach 010, then predict 040
    s = idle(); s.pred = 1; s.pbt = 'h010; step(s);
    s = idle(); s.pred = 1; s.pbt = 'h040; step(s);
    s = idle(); step(s);

    // correction to CNI beats a simultaneous prediction; two squash cycles
    s = idle(); s.corr = 2; s.ecni = 'h023; s.pred = 1; s.pbt = 'h3A0; step(s);
    s = idle(); s.pred = 1; s.pbt = 'h3A0; step(s);
    s = idle(); step(s);

    // correction during stall is held pending, applied after stall
    s = idle(); s.stall = 1; step(s);
    s = idle(); s.stall = 1; s.corr = 3; s.epbt = 'h055; step(s);
    s = idle(); s.stall = 1; step(s);
    s = idle(); step(s);
    s = idle(); step(s);
    s = idle(); step(s);

    // interrupt entry at 030 and return; request deferred by a flush
    s = idle(); s.pred = 1; s.pbt = 'h030; step(s);
    s = idle(); s.ireq = 1; step(s);
    s = idle(); s.ireq = 1; step(s);     // ignored: already running
    s = idle(); step(s);
    s = idle(); s.iret = 1; s.ireq = 1; step(s);  // return wins
    s = idle(); s.ireq = 1; s.corr = 2; s.ecni = 'h200; step(s);
    s = idle(); s.ireq = 1; step(s);     // still flushing
    s = idle(); s.ireq = 1; step(s);     // taken now
    s = idle(); s.iret = 1; step(s);
    s = idle(); s.jmp = 1; s.jt = 'h444; step(s);
    s = idle(); s.jmp = 1; s.inbht = 1; s.jt = 'h111; step(s);

    // wrap at the top of the address space
    s = idle(); s.pred = 1; s.pbt = 'h7FE; step(s);
    s = idle(); step(s);
    s = idle(); s.pred = 1; s.pbt = 'h7FF; step(s);
    s = idle(); s.comp = 1; step(s);
    s = idle(); step(s);

    // en=0 freezes everything, even with activity on the inputs
    s = idle(); s.en = 0; s.corr = 3; s.epbt = 'h321; s.ireq = 1; step(s);
    s = idle(); s.en = 0; s.stall = 1; s.corr = 3; s.epbt = 'h321; step(s);
    s = idle(); step(s);

    // three mispredicts, then reset mid-count and mid-flush
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.corr = 3; s.epbt = 'h080 + i; step(s);
      s = idle(); step(s);
    end
    s = idle(); s.corr = 2; s.ecni = 'h0F0; step(s);
    s = idle(); s.rst = 1; step(s);
    s = idle(); step(s);
    s = idle(); step(s);

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 399) == 0);
      s.en    = ($urandom_range(0, 9) != 0);
      s.stall = ($urandom_range(0, 6) == 0);
      s.comp  = $urandom_range(0, 1);
      s.pred  = ($urandom_range(0, 4) == 0);
      s.pbt   = $urandom_range(0, 2047);
      s.jmp   = ($urandom_range(0, 6) == 0);
      s.inbht = $urandom_range(0, 1);
      s.jt    = $urandom_range(0, 2047);
      s.corr  = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1);
      s.epbt  = $urandom_range(0, 2047);
      s.ecni  = $urandom_range(0, 2047);
      s.ireq  = ($urandom_range(0, 7) == 0);
      s.iret  = ($urandom_range(0, 7) == 0);
      step(s);
    end

    // let the monitor drain the queue, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge CLK);
    #6;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
